// File: rtl/bdc_pkg.sv
// Shared types and defaults for the barrel distortion correction line scheduler.
package bdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int BDC_WIDTH        = 1920;
  localparam int BDC_HEIGHT       = 1080;
  localparam int BDC_BUFFER_LINES = 4;
  localparam int BDC_MARGIN       = 1;

  function automatic int slot_width(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/bdc_ring_counter.sv
// Wrapping ring-slot counter: clear forces slot 0, advance steps DEPTH-1 -> 0.
// Clear and advance together yield slot 1 (first row of a restarted frame done).
module bdc_ring_counter
  import bdc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SW    = slot_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [SW-1:0] value
);

  logic [SW-1:0] base;

  always_comb begin
    base = clear ? '0 : value;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear || advance) begin
      if (advance) begin
        value <= (base == SW'(DEPTH - 1)) ? '0 : base + SW'(1);
      end else begin
        value <= base;
      end
    end
  end

endmodule

// File: rtl/bdc_line_scheduler.sv
// Writes the input stream into the line-buffer ring and grants output rows once all
// referenced source rows are resident; input stalls while a needed slot is still in use.
module bdc_line_scheduler
  import bdc_pkg::*;
#(
  parameter int WIDTH        = BDC_WIDTH,
  parameter int HEIGHT       = BDC_HEIGHT,
  parameter int DATA_WIDTH   = 24,
  parameter int COORD_WIDTH  = 16,
  parameter int BUFFER_LINES = BDC_BUFFER_LINES,
  parameter int MARGIN       = BDC_MARGIN
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  input  logic                                  s_axis_tuser,
  output logic                                  wr_en,
  output logic [slot_width(BUFFER_LINES)-1:0]   wr_slot,
  output logic [COORD_WIDTH-1:0]                wr_addr,
  output logic [DATA_WIDTH-1:0]                 wr_data,
  output logic                                  row_valid,
  output logic [COORD_WIDTH-1:0]                row_y,
  output logic [slot_width(BUFFER_LINES)-1:0]   row_slot,
  input  logic                                  row_done,
  output logic                                  frame_done,
  output logic                                  sof_err,
  output logic                                  eol_err
);

  localparam int SW = slot_width(BUFFER_LINES);
  localparam int CW = COORD_WIDTH;

  if (BUFFER_LINES < 2 * MARGIN + 1) begin : g_bad_cfg
    $error("bdc_line_scheduler: BUFFER_LINES must be >= 2*MARGIN+1");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] wr_x, wr_row, rd_row;
  logic [SW-1:0] wr_slot_q, rd_slot_q;
  logic [CW-1:0] x_eff, row_eff;
  logic [31:0]   need_rows, grant_need;
  logic          hs, sof, sof_mid, row_end, retire, frame_end, grant, room;

  assign hs        = s_axis_tvalid & s_axis_tready;
  assign sof       = hs & s_axis_tuser;
  assign sof_mid   = sof && (state == ST_RUN) && ((wr_x != '0) || (wr_row != '0));
  // A start-of-frame beat is always pixel (0,0), whatever the counters held.
  assign x_eff     = sof ? '0 : wr_x;
  assign row_eff   = sof ? '0 : wr_row;
  assign row_end   = wr_en && (x_eff == CW'(WIDTH - 1));
  assign retire    = row_done && row_valid;
  assign frame_end = retire && (rd_row == CW'(HEIGHT - 1));

  // Slot of rd_row is reused by row rd_row+BUFFER_LINES; keep MARGIN rows behind it.
  assign room       = 32'(wr_row) < 32'(rd_row) + 32'(BUFFER_LINES - MARGIN);
  assign need_rows  = 32'(rd_row) + 32'(MARGIN + 1);
  assign grant_need = (need_rows < 32'(HEIGHT)) ? need_rows : 32'(HEIGHT);
  assign grant      = (state != ST_IDLE) && !row_valid && (32'(wr_row) >= grant_need);

  assign wr_slot  = sof ? '0 : wr_slot_q;
  assign wr_addr  = x_eff;
  assign wr_data  = s_axis_tdata;
  assign row_y    = rd_row;
  assign row_slot = rd_slot_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (sof) state_nxt = ST_RUN;
      ST_RUN:   if (row_end && (row_eff == CW'(HEIGHT - 1))) state_nxt = ST_DRAIN;
      ST_DRAIN: if (frame_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      ST_IDLE: s_axis_tready = 1'b1;
      ST_RUN:  s_axis_tready = (32'(wr_row) < 32'(HEIGHT)) && room;
      default: s_axis_tready = 1'b0;
    endcase
    if (!rst_n) s_axis_tready = 1'b0;
    wr_en = s_axis_tvalid && s_axis_tready && ((state == ST_RUN) || s_axis_tuser);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_x       <= '0;
      wr_row     <= '0;
      rd_row     <= '0;
      row_valid  <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      eol_err    <= 1'b0;
    end else begin
      frame_done <= frame_end;
      sof_err    <= sof_mid;
      eol_err    <= wr_en && (s_axis_tlast != (x_eff == CW'(WIDTH - 1)));

      if (wr_en) begin
        if (row_end) begin
          wr_x   <= '0;
          wr_row <= row_eff + CW'(1);
        end else begin
          wr_x   <= x_eff + CW'(1);
          wr_row <= row_eff;
        end
      end else if (frame_end) begin
        wr_x   <= '0;
        wr_row <= '0;
      end

      if (sof_mid || frame_end) begin
        rd_row    <= '0;
        row_valid <= 1'b0;
      end else if (retire) begin
        rd_row    <= rd_row + CW'(1);
        row_valid <= 1'b0;
      end else if (grant) begin
        row_valid <= 1'b1;
      end
    end
  end

  bdc_ring_counter #(.DEPTH(BUFFER_LINES)) u_wr_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (sof | frame_end),
    .advance (row_end),
    .value   (wr_slot_q)
  );

  bdc_ring_counter #(.DEPTH(BUFFER_LINES)) u_rd_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (sof_mid | frame_end),
    .advance (retire & ~(sof_mid | frame_end)),
    .value   (rd_slot_q)
  );

endmodule

// File: tb/tb_bdc_line_scheduler.sv
// Directed bench for bdc_line_scheduler with an 8x6 frame in a 4-line ring, MARGIN 1.
module tb_bdc_line_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic        wr_en;
  logic [1:0]  wr_slot;
  logic [15:0] wr_addr;
  logic [23:0] wr_data;
  logic        row_valid;
  logic [15:0] row_y;
  logic [1:0]  row_slot;
  logic        row_done, frame_done, sof_err, eol_err;

  int checks = 0;
  int errors = 0;

  logic        b_en, b_rdy;
  logic [15:0] b_addr;
  logic [1:0]  b_slot;
  logic [23:0] b_data, sent_data;

  always #5 clk = ~clk;

  bdc_line_scheduler #(
    .WIDTH(8), .HEIGHT(6), .DATA_WIDTH(24), .COORD_WIDTH(16),
    .BUFFER_LINES(4), .MARGIN(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .wr_en         (wr_en),
    .wr_slot       (wr_slot),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .row_valid     (row_valid),
    .row_y         (row_y),
    .row_slot      (row_slot),
    .row_done      (row_done),
    .frame_done    (frame_done),
    .sof_err       (sof_err),
    .eol_err       (eol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One offered beat; captures the combinational write-port outputs before the edge.
  task automatic beat(input logic user, input logic last);
    sent_data     = 24'(32'h5A0000 + 32'(checks * 7 + 1));
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = user;
    s_axis_tlast  = last;
    s_axis_tdata  = sent_data;
    #1;
    b_en   = wr_en;
    b_rdy  = s_axis_tready;
    b_addr = wr_addr;
    b_slot = wr_slot;
    b_data = wr_data;
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_row(input int slot);
    for (int x = 0; x < 8; x++) begin
      beat(1'b0, x == 7);
      if (x == 0) chk("row_first_slot", 32'(b_slot), slot);
    end
    chk("row_last_en", 32'(b_en), 1);
  endtask

  task automatic retire(input int y, input int slot);
    int waited = 0;
    while (row_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk("grant_wait", 32'(row_valid), 1);
    chk("grant_row_y", 32'(row_y), y);
    chk("grant_slot", 32'(row_slot), slot);
    row_done = 1'b1;
    step();
    row_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; row_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1;
    #1;
    chk("rst_tready", 32'(s_axis_tready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_row_valid", 32'(row_valid), 0);
    chk("rst_row_y", 32'(row_y), 0);
    chk("rst_row_slot", 32'(row_slot), 0);
    chk("rst_pulses", {29'd0, frame_done, sof_err, eol_err}, 0);
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_tready", 32'(s_axis_tready), 1);

    // Frame 1: discard beats until SOF
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b0);
      chk("idle_discard", 32'(b_en), 0);
    end
    beat(1'b1, 1'b0);
    chk("sof_en", 32'(b_en), 1);
    chk("sof_addr", 32'(b_addr), 0);
    chk("sof_slot", 32'(b_slot), 0);
    chk("sof_data", 32'(b_data), 32'(sent_data));
    for (int x = 1; x < 8; x++) beat(1'b0, x == 7);
    step(); step();
    chk("one_row_no_grant", 32'(row_valid), 0);

    send_row(1);
    chk("grant_edge1", 32'(row_valid), 0);
    chk("good_eol", 32'(eol_err), 0);
    step();
    chk("grant_edge2", 32'(row_valid), 1);
    chk("grant0_y", 32'(row_y), 0);
    chk("grant0_slot", 32'(row_slot), 0);

    send_row(2);
    chk("ring_full_tready", 32'(s_axis_tready), 0);
    beat(1'b0, 1'b0);
    chk("ring_full_no_write", 32'(b_en), 0);

    retire(0, 0);
    chk("after_done_gap", 32'(row_valid), 0);
    chk("after_done_tready", 32'(s_axis_tready), 1);
    row_done = 1'b1;
    step();
    row_done = 1'b0;
    chk("stray_done_ignored", 32'(row_valid), 1);
    chk("stray_done_row_y", 32'(row_y), 1);
    chk("stray_done_slot", 32'(row_slot), 1);

    send_row(3);
    chk("row3_full_tready", 32'(s_axis_tready), 0);
    retire(1, 1);
    send_row(0);
    chk("row4_full_tready", 32'(s_axis_tready), 0);
    retire(2, 2);
    send_row(1);
    chk("drain_tready", 32'(s_axis_tready), 0);
    retire(3, 3);
    retire(4, 0);
    retire(5, 1);
    chk("frame_done_pulse", 32'(frame_done), 1);
    chk("frame_done_rv", 32'(row_valid), 0);
    chk("frame_done_tready", 32'(s_axis_tready), 1);
    chk("frame_done_row_y", 32'(row_y), 0);
    step();
    chk("frame_done_low", 32'(frame_done), 0);

    // Frame 2: mid-frame SOF and misplaced/missing tlast
    beat(1'b1, 1'b0);
    chk("f2_sof_en", 32'(b_en), 1);
    chk("f2_sof_slot", 32'(b_slot), 0);
    for (int x = 1; x < 8; x++) beat(1'b0, x == 7);
    send_row(1);
    for (int x = 0; x < 3; x++) begin
      beat(1'b0, 1'b0);
      if (x == 0) chk("f2_row2_slot", 32'(b_slot), 2);
    end
    chk("f2_granted", 32'(row_valid), 1);
    beat(1'b1, 1'b0);
    chk("midsof_en", 32'(b_en), 1);
    chk("midsof_addr", 32'(b_addr), 0);
    chk("midsof_slot", 32'(b_slot), 0);
    chk("midsof_err", 32'(sof_err), 1);
    chk("midsof_drop_grant", 32'(row_valid), 0);
    beat(1'b0, 1'b0);
    chk("midsof_err_low", 32'(sof_err), 0);
    chk("midsof_next_addr", 32'(b_addr), 1);
    for (int x = 2; x < 5; x++) beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    chk("early_tlast_addr", 32'(b_addr), 5);
    chk("early_tlast_err", 32'(eol_err), 1);
    beat(1'b0, 1'b0);
    chk("count_continues", 32'(b_addr), 6);
    chk("eol_err_low", 32'(eol_err), 0);
    beat(1'b0, 1'b0);
    chk("missing_tlast_addr", 32'(b_addr), 7);
    chk("missing_tlast_err", 32'(eol_err), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bdc_line_scheduler.md
# bdc_line_scheduler

Line-buffer scheduler for the barrel distortion correction datapath. It accepts the input AXI4-Stream and writes pixels into the BUFFER_LINES-deep line-buffer ring. It grants output rows to the correction datapath only once every source row they can reference is resident. It back-pressures the input so that no ring slot is overwritten while an in-progress output row may still read it.

## Interface
Parameters:
- WIDTH, 1920, pixels per row
- HEIGHT, 1080, rows per frame
- DATA_WIDTH, 24, pixel width
- COORD_WIDTH, 16, row/column counter width
- BUFFER_LINES, 4, ring depth in rows
- MARGIN, 1, maximum vertical source displacement in rows; BUFFER_LINES >= 2*MARGIN+1 is checked by elaboration-time assertion

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  DATA_WIDTH  input pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (combinational from registers; 0 while rst_n low)
- s_axis_tlast  in  1  end of row
- s_axis_tuser  in  1  start of frame
- wr_en  out  1  ring write strobe (= tvalid & tready & writing)
- wr_slot  out  clog2(BUFFER_LINES)  ring slot being written
- wr_addr  out  COORD_WIDTH  column being written
- wr_data  out  DATA_WIDTH  = s_axis_tdata
- row_valid  out  1  output row granted (registered)
- row_y  out  COORD_WIDTH  granted output row
- row_slot  out  clog2(BUFFER_LINES)  ring slot holding input row row_y
- row_done  in  1  datapath finished row row_y (single-cycle pulse)
- frame_done  out  1  one-cycle pulse after last row completes
- sof_err  out  1  one-cycle pulse: tuser mid-frame
- eol_err  out  1  one-cycle pulse: tlast misplaced or missing

## Operation
- Registers: state, wr_x, wr_row (0..HEIGHT), wr_slot, rd_row (0..HEIGHT-1), rd_slot. Slots wrap BUFFER_LINES-1 -> 0 independently of the row counters; no modulo operator is used.
- States: IDLE, RUN, DRAIN.
- IDLE: s_axis_tready=1. Beats with tuser=0 are discarded (wr_en=0). A beat with tuser=1 is written as pixel (0,0) in slot 0, and the block moves to RUN.
- RUN: each accepted beat writes (wr_slot, wr_x). At wr_x==WIDTH-1: wr_x<=0, wr_row++, wr_slot advances. When wr_row reaches HEIGHT, the block moves to DRAIN.
- Write permission (RUN only): s_axis_tready = (wr_row < HEIGHT) && (wr_row < rd_row + BUFFER_LINES - MARGIN).
- Grant condition: wr_row >= min(rd_row+MARGIN+1, HEIGHT).
- row_valid is set on the edge after the grant condition holds. It is held with row_y=rd_row, row_slot=rd_slot until row_done.
- On row_done while row_valid: row_valid<=0, rd_row++, rd_slot advances. row_done while !row_valid is ignored.
- DRAIN: s_axis_tready=0; grants continue. row_done for row HEIGHT-1 pulses frame_done and moves the block to IDLE with all counters cleared.
- tuser=1 on an accepted beat in RUN with (wr_x,wr_row)!=(0,0): sof_err pulses, the outstanding grant is dropped (row_valid<=0), and all counters are cleared. The beat is written as pixel (0,0) of the new frame.
- tlast=1 with wr_x!=WIDTH-1, or tlast=0 with wr_x==WIDTH-1: eol_err pulses. Counting uses wr_x only; tlast never alters counters.
- A write and row_done in the same cycle both take effect; the ready term uses pre-edge rd_row.

## Timing
- Reset values: state=IDLE, all counters 0, row_valid=0, row_y=0, row_slot=0, frame_done=0, sof_err=0, eol_err=0, wr_en=0, s_axis_tready=0 while rst_n low. Reset mid-frame abandons the frame and any grant.
- Write path has zero latency: wr_* are valid in the handshake cycle.
- Grant latency: row_valid rises on the 2nd edge after the handshake of the last pixel of row min(y+MARGIN, HEIGHT-1).
- After row_done, row_valid is low for at least one cycle before the next grant.
- Input stalls during DRAIN; the next frame's SOF is accepted from the cycle after frame_done.

## Structure
- Package bdc_pkg: state encoding, slot width function, and default WIDTH/HEIGHT/BUFFER_LINES/MARGIN shared with barrel_distortion_correction.
- Sub-module bdc_ring_counter: wrapping slot counter (clear, advance), instantiated for wr_slot and rd_slot.

## Test plan
Parameters for all scenarios: WIDTH=8, HEIGHT=6, BUFFER_LINES=4, MARGIN=1.
- Reset: all outputs 0 during reset -> tready=1 the cycle after release.
- 3 beats with tuser=0, then a beat with tuser=1 -> the first three give wr_en=0; the fourth gives wr_en=1, wr_addr=0, wr_slot=0.
- Stream 8 beats -> row_valid stays 0; stream 16 beats -> row_valid=1, row_y=0, row_slot=0 on the 2nd edge after the last beat.
- No row_done, stream 24 beats -> tready=0 at row 3. Pulse row_done -> tready=1; row 3 is written to slot 3 and row 4 to slot 0 (after row 1 is done).
- Row 5 granted once wr_row=6 -> row_done -> frame_done pulse, state IDLE, tready=1.
- tuser at row 2, x=3 -> sof_err pulse, row_valid=0, wr_addr=0, wr_slot=0. tlast at x=5 -> eol_err pulse; wr_x continues to 6.
